// File: rtl/fetch_stage.sv
// Instruction fetch / pre-decode: owns the PC, assembles one- and two-word instructions.
// Optional boot-vector fetch from words 0/1 when FETCH_RESET_VECTOR_EN is defined.
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [15:0]           imem_rdata,
  input  logic                  stall,
  input  logic                  jump_occured,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [4:0]            opcode,
  output logic [2:0]            rdst,
  output logic [2:0]            rsrc,
  output logic [15:0]           immediate,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_IMM   = 2'd1;
  localparam logic [1:0] ST_BOOT0 = 2'd2;
  localparam logic [1:0] ST_BOOT1 = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            state_q, state_d;
  logic [15:0]           hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [4:0]            opcode_q, opcode_d;
  logic [2:0]            rdst_q, rdst_d;
  logic [2:0]            rsrc_q, rsrc_d;
  logic [15:0]           imm_q, imm_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                  two_word;

  assign two_word = (imem_rdata[15:11] == 5'd14) || (imem_rdata[15:11] == 5'd30) ||
                    (imem_rdata[15:11] == 5'd31);

`ifdef FETCH_RESET_VECTOR_EN
  logic [15:0]           vec_lo_q, vec_lo_d;
  logic [31:0]           boot_word;
  logic [ADDR_WIDTH-1:0] boot_vec;

  assign boot_word = {imem_rdata, vec_lo_q};
  // Vector is 32 bits wide in memory; fit it to the PC width.
  if (ADDR_WIDTH >= 32) begin : g_vec_pad
    assign boot_vec = {{(ADDR_WIDTH-32){1'b0}}, boot_word};
  end else begin : g_vec_trunc
    assign boot_vec = boot_word[ADDR_WIDTH-1:0];
  end

  always_comb begin
    imem_addr = pc_q;
    if (state_q == ST_BOOT0) imem_addr = '0;
    else if (state_q == ST_BOOT1) imem_addr = ONE;
  end
`else
  assign imem_addr = pc_q;
`endif

  always_comb begin
    pc_d      = pc_q;
    state_d   = state_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    opcode_d  = opcode_q;
    rdst_d    = rdst_q;
    rsrc_d    = rsrc_q;
    imm_d     = imm_q;
    valid_d   = valid_q;
    pc_out_d  = pc_out_q;
`ifdef FETCH_RESET_VECTOR_EN
    vec_lo_d  = vec_lo_q;
    if (state_q == ST_BOOT0 || state_q == ST_BOOT1) begin
      if (!stall) begin
        if (state_q == ST_BOOT0) begin
          vec_lo_d = imem_rdata;
          state_d  = ST_BOOT1;
        end else begin
          pc_d    = boot_vec;
          state_d = ST_FETCH;
        end
      end
    end else
`endif
    if (jump_occured) begin
      pc_d     = jump_target;
      state_d  = ST_FETCH;
      opcode_d = '0;
      rdst_d   = '0;
      rsrc_d   = '0;
      imm_d    = '0;
      valid_d  = 1'b0;
    end else if (!stall) begin
      pc_d = pc_q + ONE;
      if (state_q == ST_IMM) begin
        opcode_d = hold_q[15:11];
        rdst_d   = hold_q[10:8];
        rsrc_d   = hold_q[7:5];
        imm_d    = imem_rdata;
        valid_d  = 1'b1;
        pc_out_d = hold_pc_q;
        state_d  = ST_FETCH;
      end else if (two_word) begin
        // First word parked; emit a bubble while the immediate is fetched.
        hold_d    = imem_rdata;
        hold_pc_d = pc_q;
        state_d   = ST_IMM;
        opcode_d  = '0;
        rdst_d    = '0;
        rsrc_d    = '0;
        imm_d     = '0;
        valid_d   = 1'b0;
      end else begin
        opcode_d = imem_rdata[15:11];
        rdst_d   = imem_rdata[10:8];
        rsrc_d   = imem_rdata[7:5];
        imm_d    = '0;
        valid_d  = 1'b1;
        pc_out_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
`ifdef FETCH_RESET_VECTOR_EN
      state_q   <= ST_BOOT0;
      vec_lo_q  <= '0;
`else
      state_q   <= ST_FETCH;
`endif
      hold_q    <= '0;
      hold_pc_q <= '0;
      opcode_q  <= '0;
      rdst_q    <= '0;
      rsrc_q    <= '0;
      imm_q     <= '0;
      valid_q   <= 1'b0;
      pc_out_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
`ifdef FETCH_RESET_VECTOR_EN
      vec_lo_q  <= vec_lo_d;
`endif
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
      opcode_q  <= opcode_d;
      rdst_q    <= rdst_d;
      rsrc_q    <= rsrc_d;
      imm_q     <= imm_d;
      valid_q   <= valid_d;
      pc_out_q  <= pc_out_d;
    end
  end

  assign opcode      = opcode_q;
  assign rdst        = rdst_q;
  assign rsrc        = rsrc_q;
  assign immediate   = imm_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps then random stall/jump traffic against an instruction-level model.
module tb_fetch_stage;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          jump_occured = 1'b0;
  logic [AW-1:0] jump_target = '0;
  logic [AW-1:0] imem_addr, pc_out;
  logic [15:0]   imem_rdata, immediate;
  logic [4:0]    opcode;
  logic [2:0]    rdst, rsrc;
  logic          instr_valid;

  logic [15:0] mem [256];
  assign imem_rdata = mem[imem_addr[7:0]];

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .jump_occured(jump_occured), .jump_target(jump_target),
    .opcode(opcode), .rdst(rdst), .rsrc(rsrc), .immediate(immediate),
    .instr_valid(instr_valid), .pc_out(pc_out)
  );

  int checks = 0;
  int errors = 0;

  // Model: a PC, a queue of pending first words, and the instruction last presented.
  logic [31:0] m_pc;
  logic [15:0] pend_w[$];
  logic [31:0] pend_pc[$];
  logic [4:0]  m_op;
  logic [2:0]  m_rdst, m_rsrc;
  logic [15:0] m_imm;
  logic        m_valid;
  logic [31:0] m_pcout;
  int          m_boot;
  logic [15:0] m_vlo;

  function automatic bit is_two_word(input logic [4:0] op);
    return (op == 5'd14) || (op == 5'd30) || (op == 5'd31);
  endfunction

  function automatic logic [31:0] exp_addr();
    if (m_boot == 2) return 32'd0;
    if (m_boot == 1) return 32'd1;
    return m_pc;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0;
    pend_w.delete();
    pend_pc.delete();
    m_op = '0; m_rdst = '0; m_rsrc = '0; m_imm = '0; m_valid = 1'b0; m_pcout = '0;
`ifdef FETCH_RESET_VECTOR_EN
    m_boot = 2;
`else
    m_boot = 0;
`endif
  endtask

  task automatic model_edge(input bit s, input bit j, input logic [31:0] t);
    logic [31:0] a;
    logic [15:0] w;
    a = exp_addr();
    w = mem[a[7:0]];
    if (m_boot > 0) begin
      if (!s) begin
        if (m_boot == 2) m_vlo = w;
        else m_pc = {w, m_vlo};
        m_boot--;
      end
    end else if (j) begin
      m_pc = t;
      pend_w.delete();
      pend_pc.delete();
      m_op = '0; m_rdst = '0; m_rsrc = '0; m_imm = '0; m_valid = 1'b0;
    end else if (!s) begin
      if (pend_w.size() > 0) begin
        logic [15:0] fw;
        fw = pend_w.pop_front();
        m_pcout = pend_pc.pop_front();
        m_op = fw[15:11]; m_rdst = fw[10:8]; m_rsrc = fw[7:5];
        m_imm = w; m_valid = 1'b1;
      end else if (is_two_word(w[15:11])) begin
        pend_w.push_back(w);
        pend_pc.push_back(m_pc);
        m_op = '0; m_rdst = '0; m_rsrc = '0; m_imm = '0; m_valid = 1'b0;
      end else begin
        m_op = w[15:11]; m_rdst = w[10:8]; m_rsrc = w[7:5];
        m_imm = '0; m_valid = 1'b1; m_pcout = m_pc;
      end
      m_pc = m_pc + 32'd1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("imem_addr", imem_addr, exp_addr());
    check("opcode", {27'd0, opcode}, {27'd0, m_op});
    check("rdst", {29'd0, rdst}, {29'd0, m_rdst});
    check("rsrc", {29'd0, rsrc}, {29'd0, m_rsrc});
    check("immediate", {16'd0, immediate}, {16'd0, m_imm});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    if (m_valid) check("pc_out", pc_out, m_pcout);
  endtask

  task automatic step(input bit s, input bit j, input logic [31:0] t);
    stall = s;
    jump_occured = j;
    jump_target = t;
    model_edge(s, j, t);
    @(posedge clk);
    #1;
    $display("t=%0t stall=%b jump=%b tgt=%h | addr=%h op=%0d rd=%0d rs=%0d imm=%h v=%b pc_out=%h",
             $time, s, j, t, imem_addr, opcode, rdst, rsrc, immediate, instr_valid, pc_out);
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h2100; mem[1] = 16'hC940; mem[2] = 16'h0800; mem[3] = 16'h1000;
    mem[4] = 16'h7200; mem[5] = 16'hBEEF; mem[6] = 16'hF000;
    mem[8'h40] = 16'h1234; mem[8'hFF] = 16'h0800;
`ifdef FETCH_RESET_VECTOR_EN
    mem[0] = 16'h0100; mem[1] = 16'h0000;
`endif
    model_reset();
    #12;
    check_all();
    check("rst_pc_out", pc_out, 32'd0);
    rst_n = 1'b1;

`ifdef FETCH_RESET_VECTOR_EN
    check("boot_addr0", imem_addr, 32'd0);
    step(0, 0, 0);
    check("boot_addr1", imem_addr, 32'd1);
    step(0, 0, 0);
    check("boot_vec", imem_addr, 32'h100);
    step(0, 0, 0);
    check("boot_first_pc", pc_out, 32'h100);
    check("boot_first_v", {31'd0, instr_valid}, 32'd1);
`else
    step(0, 0, 0);
    check("inc_op", {27'd0, opcode}, 32'd4);
    check("inc_pc", pc_out, 32'd0);
    step(0, 0, 0);
    check("add_op", {27'd0, opcode}, 32'd25);
    check("add_pc", pc_out, 32'd1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("ldm_bubble", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0);
    check("ldm_op", {27'd0, opcode}, 32'd14);
    check("ldm_rdst", {29'd0, rdst}, 32'd2);
    check("ldm_imm", {16'd0, immediate}, 32'h0000BEEF);
    check("ldm_pc", pc_out, 32'd4);
    check("ldm_next", imem_addr, 32'd6);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      check("stall_addr", imem_addr, 32'd6);
      check("stall_op", {27'd0, opcode}, 32'd14);
    end
    step(0, 0, 0);
    check("resume_addr", imem_addr, 32'd7);
    step(1, 1, 32'h40);
    check("jmp_op", {27'd0, opcode}, 32'd0);
    check("jmp_v", {31'd0, instr_valid}, 32'd0);
    check("jmp_addr", imem_addr, 32'h40);
    step(0, 0, 0);
    check("tgt_op", {27'd0, opcode}, 32'd2);
    check("tgt_pc", pc_out, 32'h40);
    step(0, 1, 32'hFFFF_FFFF);
    step(0, 0, 0);
    check("wrap_pc", pc_out, 32'hFFFF_FFFF);
    check("wrap_addr", imem_addr, 32'd0);
    step(0, 1, 32'd3);
    step(0, 0, 0);
    step(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("arst_pc_out", pc_out, 32'd0);
    #2 rst_n = 1'b1;
    step(0, 0, 0);
    check("rel_op", {27'd0, opcode}, 32'd4);
    check("rel_pc", pc_out, 32'd0);
`endif

    for (int k = 0; k < 400; k++) begin
      bit s, j;
      logic [31:0] t;
      s = ($urandom_range(0, 4) == 0);
      j = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 7) == 0) ? {24'hFFFFFF, 8'($urandom)} : 32'($urandom_range(0, 255));
      step(s, j, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
